// File: rtl/sell_ledger_if.sv
//------------------------------------------------------------------------------
// Module      : sell_ledger_if
// Description : Sell-order bus between the sell menu (master) and the ledger
//               (slave): request operands in, holdings/cash/status out.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface sell_ledger_if;
    logic        sell_req;
    logic [7:0]  stockA_sold;
    logic [7:0]  stockC_sold;
    logic [11:0] stockA_price;
    logic [11:0] stockC_price;
    logic [7:0]  stockA_qty;
    logic [7:0]  stockC_qty;
    logic [23:0] current_cash;
    logic        busy;
    logic        done;
    logic        error;

    modport master (
        output sell_req, stockA_sold, stockC_sold, stockA_price, stockC_price,
        input  stockA_qty, stockC_qty, current_cash, busy, done, error
    );

    modport slave (
        input  sell_req, stockA_sold, stockC_sold, stockA_price, stockC_price,
        output stockA_qty, stockC_qty, current_cash, busy, done, error
    );
endinterface

`default_nettype wire

// File: rtl/sell_ledger.sv
//------------------------------------------------------------------------------
// Module      : sell_ledger
// Description : Cash / crop-holding ledger that validates and commits sell
//               orders using a sequential shift-add multiplier per line.
//               Optional per-line fee enabled by macro SELL_LEDGER_FEE_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sell_ledger #(
    parameter logic [23:0] INIT_CASH  = 24'h000100,
    parameter logic [7:0]  INIT_QTY_A = 8'h20,
    parameter logic [7:0]  INIT_QTY_C = 8'h10
`ifdef SELL_LEDGER_FEE_EN
    ,
    parameter logic [11:0] FEE        = 12'h005
`endif
) (
    input  wire logic    clock_50,
    input  wire logic    resetn,
    sell_ledger_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_ERR    = 3'd2,
        S_MUL_A  = 3'd3,
        S_MUL_C  = 3'd4,
        S_COMMIT = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    localparam logic [23:0] c_cash_max = 24'hFFFFFF;

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic [19:0] r_mcand;
    logic [7:0]  r_mplier;
    logic [19:0] r_acc;
    logic [19:0] r_prod_a;
    logic [7:0]  r_sold_a;
    logic [7:0]  r_sold_c;
    logic [11:0] r_price_c;
    logic [7:0]  r_qty_a;
    logic [7:0]  r_qty_c;
    logic [23:0] r_cash;
    logic        r_busy;
    logic        r_done;
    logic        r_error;

    logic [19:0] w_acc_next;
    logic [19:0] w_line_a;
    logic [19:0] w_line_c;
    logic [24:0] w_sum;
    logic [23:0] w_cash_next;

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : 20'd0);

    // In COMMIT, r_prod_a holds the A product and r_acc the C product.
`ifdef SELL_LEDGER_FEE_EN
    localparam logic [19:0] c_fee = {8'd0, FEE};
    assign w_line_a = (r_sold_a == 8'd0 || r_prod_a < c_fee) ? 20'd0 : r_prod_a - c_fee;
    assign w_line_c = (r_sold_c == 8'd0 || r_acc < c_fee)    ? 20'd0 : r_acc - c_fee;
`else
    assign w_line_a = r_prod_a;
    assign w_line_c = r_acc;
`endif

    assign w_sum       = {1'b0, r_cash} + {5'd0, w_line_a} + {5'd0, w_line_c};
    assign w_cash_next = w_sum[24] ? c_cash_max : w_sum[23:0];

    always_ff @(posedge clock_50 or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_cnt     <= 3'd0;
            r_mcand   <= 20'd0;
            r_mplier  <= 8'd0;
            r_acc     <= 20'd0;
            r_prod_a  <= 20'd0;
            r_sold_a  <= 8'd0;
            r_sold_c  <= 8'd0;
            r_price_c <= 12'd0;
            r_qty_a   <= INIT_QTY_A;
            r_qty_c   <= INIT_QTY_C;
            r_cash    <= INIT_CASH;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.sell_req) begin
                        r_mcand   <= {8'd0, bus.stockA_price};
                        r_mplier  <= bus.stockA_sold;
                        r_sold_a  <= bus.stockA_sold;
                        r_sold_c  <= bus.stockC_sold;
                        r_price_c <= bus.stockC_price;
                        r_acc     <= 20'd0;
                        r_cnt     <= 3'd0;
                        r_error   <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (r_sold_a > r_qty_a || r_sold_c > r_qty_c)
                        r_state <= S_ERR;
                    else
                        r_state <= S_MUL_A;
                end
                S_ERR: begin
                    r_error <= 1'b1;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_MUL_A: begin
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        // Park the A product and reload the shifter for line C.
                        r_prod_a <= w_acc_next;
                        r_acc    <= 20'd0;
                        r_mcand  <= {8'd0, r_price_c};
                        r_mplier <= r_sold_c;
                        r_state  <= S_MUL_C;
                    end else begin
                        r_acc    <= w_acc_next;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                    end
                end
                S_MUL_C: begin
                    r_cnt    <= r_cnt + 3'd1;
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    if (r_cnt == 3'd7)
                        r_state <= S_COMMIT;
                end
                S_COMMIT: begin
                    r_qty_a <= r_qty_a - r_sold_a;
                    r_qty_c <= r_qty_c - r_sold_c;
                    r_cash  <= w_cash_next;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.stockA_qty   = r_qty_a;
    assign bus.stockC_qty   = r_qty_c;
    assign bus.current_cash = r_cash;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.error        = r_error;

endmodule

`default_nettype wire

// File: doc/sell_ledger.md
# sell_ledger

Portfolio ledger that executes the sell order issued by the sell menu. It holds the player's cash and the per-crop stock quantities (A and C). On each sell request it validates the requested quantities against holdings, computes proceeds (price × quantity) with a sequential shift-add multiplier, then commits the new cash and quantities. Its outputs feed the `stockA_qty`, `stockC_qty` and `current_cash` inputs of the menu. It sits between the menu FSM and the year/market logic.

## Interface
- `INIT_CASH`, 24'h000100, cash value after reset
- `INIT_QTY_A`, 8'h20, stock A holding after reset
- `INIT_QTY_C`, 8'h10, stock C holding after reset
- `FEE`, 12'h005, flat per-line transaction fee; used only with `SELL_LEDGER_FEE_EN`
- `clock_50`  in  1  system clock; the block uses this single clock
- `resetn`  in  1  reset, asynchronous and active-low
- `sell_req`  in  1  one-cycle pulse from the menu exit; requests a sale
- `stockA_sold`  in  8  quantity of A to sell, sampled with `sell_req`
- `stockC_sold`  in  8  quantity of C to sell, sampled with `sell_req`
- `stockA_price`  in  12  unit price of A, sampled with `sell_req`
- `stockC_price`  in  12  unit price of C, sampled with `sell_req`
- `stockA_qty`  out  8  current A holding
- `stockC_qty`  out  8  current C holding
- `current_cash`  out  24  current cash
- `busy`  out  1  high from the accepting edge until `done`
- `done`  out  1  one-cycle pulse that ends every accepted request
- `error`  out  1  oversell flag; sticky until the next accepted `sell_req`

## Operation
- All values are unsigned binary. The display shows them as hex digits.
- States:
  - IDLE → CHECK on `sell_req`. At this edge all four operands are latched and `error` is cleared.
  - CHECK → ERR if `stockA_sold > stockA_qty` or `stockC_sold > stockC_qty`; otherwise → MUL_A.
  - ERR → DONE. `error` is set at this edge. Holdings and cash are untouched.
  - MUL_A: 8 shift-add iterations, LSB first, into a 20-bit accumulator (`priceA × soldA`), then → MUL_C.
  - MUL_C: same, 8 iterations for C, then → COMMIT.
  - COMMIT → DONE. At this edge:
    - `stockA_qty -= soldA`
    - `stockC_qty -= soldC`
    - `current_cash += procA + procC`
  - DONE → IDLE. `done` is high for exactly this one cycle.
- Width rules:
  - Each proceeds product is 20 bits.
  - The sum is formed at 25 bits.
  - Cash saturates at 24'hFFFFFF and never wraps.
- A zero quantity sold on a line is legal; that line contributes 0.
- If both quantities are zero, the full sequence still runs and `done` pulses with no state change.
- `sell_req` is ignored while `busy`. It is not queued.
- Operand input changes after the accepting edge have no effect.

## Timing
- Reset values:
  - `stockA_qty = INIT_QTY_A`
  - `stockC_qty = INIT_QTY_C`
  - `current_cash = INIT_CASH`
  - `busy = done = error = 0`
  - state = IDLE
- Edge numbering: edge 0 is the edge that samples `sell_req`.
  - Edge 1: CHECK resolves.
  - Edges 2–9: MUL_A.
  - Edges 10–17: MUL_C.
  - Edge 18: COMMIT; the outputs update here.
  - `done` is high during the cycle after edge 18, i.e. 19 cycles after the request.
- Error path:
  - Edge 1: → ERR.
  - Edge 2: `error` = 1, → DONE.
  - `done` is high during the cycle after edge 2.
- `busy` rises after edge 0 and falls after the `done` cycle ends. It is low in the `done` cycle's successor.
- A new `sell_req` is accepted in the same cycle that `done` is high? No. It is accepted only in IDLE, so the earliest acceptance is the edge ending the `done` cycle +1.
- Reset asserted mid-operation:
  - Immediate return to the reset values.
  - No partial commit.
  - No `done` pulse.

## Configuration
- `SELL_LEDGER_FEE_EN` defined:
  - Each line with nonzero sold quantity has `FEE` subtracted from its proceeds before the sum.
  - If the proceeds are less than `FEE`, that line's contribution is 0.
  - Latency is unchanged.
- Not defined: no fee logic, and proceeds are exact products.

## Test plan
- Basic sale:
  - Stimulus: reset defaults; priceA=0x012, priceC=0x003; soldA=0x05, soldC=0x02.
  - Response: `done` 19 cycles after the request; cash=0x000160, qtyA=0x1B, qtyC=0x0E; `error`=0.
- Oversell:
  - Stimulus: soldA=0x21 with qtyA=0x20.
  - Response: `done` 3 cycles after the request; `error`=1; all holdings and cash unchanged.
  - A following valid request clears `error` at acceptance.
- Saturation:
  - Stimulus: INIT_CASH=24'hFFFF00; priceA=0xFFF, soldA=0x10.
  - Response: cash=0xFFFFFF.
- Busy and zero sale:
  - Stimulus: second `sell_req` at edge 5 of a request.
  - Response: ignored, and exactly one `done` pulse occurs.
  - Stimulus: soldA=soldC=0.
  - Response: `done` at 19 cycles with no change.
- Reset mid-op:
  - Stimulus: assert `resetn`=0 at edge 12.
  - Response: outputs return to INIT values asynchronously and no `done` occurs.
- Fee (macro defined, FEE=0x005):
  - Stimulus: basic-sale stimulus.
  - Response: cash = 0x000100 + (0x5A-5) + (0x06-5) = 0x000156.
  - Stimulus: priceC=0x001, soldC=0x02.
  - Response: the C contribution is 0.
